// File: rtl/serdes_frame_arbiter_if.sv
// Handshake bundle between the serial requesters, the shared deserializer
// input and the frame-tag consumer of serdes_frame_arbiter.
interface serdes_frame_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int BIT_WIDTH = 32
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]                req_val;
    logic [N_REQ-1:0]                req_rdy;
    logic [N_REQ-1:0][BIT_WIDTH-1:0] req_msg;
    logic                            des_val;
    logic                            des_rdy;
    logic [BIT_WIDTH-1:0]            des_msg;
    logic                            busy;
    logic                            tag_val;
    logic                            tag_rdy;
    logic [ID_W-1:0]                 tag_id;

    modport master (
        output req_val, req_msg, des_rdy, tag_rdy,
        input  req_rdy, des_val, des_msg, busy, tag_val, tag_id
    );

    modport slave (
        input  req_val, req_msg, des_rdy, tag_rdy,
        output req_rdy, des_val, des_msg, busy, tag_val, tag_id
    );
endinterface

// File: rtl/serdes_frame_arbiter.sv
// Frame-granular arbiter sharing one deserializer between N_REQ requesters, with an
// owner-tag FIFO. Define SERDES_FRAME_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module serdes_frame_arbiter #(
    parameter int N_REQ     = 4,
    parameter int N_SAMPLES = 8,
    parameter int BIT_WIDTH = 32,
    parameter int TAG_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    serdes_frame_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(N_SAMPLES + 1);
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int OCC_W = $clog2(TAG_DEPTH + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t           state, state_nxt;
    logic [ID_W-1:0]  owner, owner_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

    logic [ID_W-1:0]  tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [OCC_W-1:0] tag_cnt;
    logic             fifo_full, tag_val_i, push, pop;
    logic [ID_W-1:0]  push_id;

    logic [ID_W-1:0]  arb_start, winner, sel;
    logic             winner_found;
    logic             des_val_c;
    logic [N_REQ-1:0] req_rdy_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef SERDES_FRAME_ARB_FIXED_PRIO_EN
    assign arb_start = '0;
`else
    logic [ID_W-1:0] rr_ptr;

    // The frame after a completed one starts its search just past that frame's owner.
    always_ff @(posedge clk) begin
        if (!reset)
            rr_ptr <= '0;
        else if (push)
            rr_ptr <= (push_id == ID_W'(N_REQ - 1)) ? '0 : push_id + ID_W'(1);
    end

    assign arb_start = rr_ptr;
`endif

    always_comb begin
        logic [ID_W-1:0] idx;
        idx          = '0;
        winner_found = 1'b0;
        winner       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(arb_start) + k) % N_REQ);
            if (!winner_found && bus.req_val[idx]) begin
                winner_found = 1'b1;
                winner       = idx;
            end
        end
    end

    assign fifo_full = (tag_cnt == OCC_W'(TAG_DEPTH));
    assign tag_val_i = (tag_cnt != '0);
    assign pop       = tag_val_i & bus.tag_rdy;

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        beat_cnt_nxt = beat_cnt;
        sel          = owner;
        push         = 1'b0;
        push_id      = owner;
        des_val_c    = 1'b0;
        req_rdy_c    = '0;
        unique case (state)
            IDLE: begin
                if (winner_found && !fifo_full) begin
                    sel               = winner;
                    push_id           = winner;
                    des_val_c         = 1'b1;
                    req_rdy_c[winner] = bus.des_rdy;
                    if (bus.des_rdy) begin
                        owner_nxt = winner;
                        if (N_SAMPLES == 1) begin
                            push = 1'b1;
                        end else begin
                            beat_cnt_nxt = CNT_W'(1);
                            state_nxt    = LOCK;
                        end
                    end
                end
            end
            LOCK: begin
                des_val_c        = bus.req_val[owner];
                req_rdy_c[owner] = bus.des_rdy;
                if (bus.req_val[owner] && bus.des_rdy) begin
                    if (beat_cnt == CNT_W'(N_SAMPLES - 1)) begin
                        push         = 1'b1;
                        beat_cnt_nxt = '0;
                        state_nxt    = IDLE;
                    end else begin
                        beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= '0;
            beat_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            tag_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            beat_cnt <= beat_cnt_nxt;
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   tag_cnt <= tag_cnt + OCC_W'(1);
                2'b01:   tag_cnt <= tag_cnt - OCC_W'(1);
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // NOTE: tag storage has no reset; tag_cnt alone marks which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= push_id;
    end

    assign bus.des_val = reset & des_val_c;
    assign bus.req_rdy = reset ? req_rdy_c : '0;
    assign bus.des_msg = bus.req_msg[sel];
    assign bus.busy    = reset & (state == LOCK);
    assign bus.tag_val = reset & tag_val_i;
    assign bus.tag_id  = (reset && tag_val_i) ? tag_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_serdes_frame_arbiter.sv
// Self-checking bench for serdes_frame_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a queue-based frame model.
module tb_serdes_frame_arbiter;
    localparam int N_REQ     = 4;
    localparam int N_SAMPLES = 8;
    localparam int BIT_WIDTH = 32;
    localparam int TAG_DEPTH = 2;
`ifdef SERDES_FRAME_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serdes_frame_arbiter_if #(.N_REQ(N_REQ), .BIT_WIDTH(BIT_WIDTH)) bus ();

    serdes_frame_arbiter #(
        .N_REQ(N_REQ), .N_SAMPLES(N_SAMPLES), .BIT_WIDTH(BIT_WIDTH), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: lock flag, owner, beats taken, round-robin start, queue of tags.
    bit  m_locked;
    int  m_owner, m_beats, m_rr;
    int  m_tags[$];

    logic [31:0] msg_base [N_REQ];
    int          seq      [N_REQ];
    int          dut_log[$];

    logic             s_des_val, s_busy, s_tag_val;
    logic [N_REQ-1:0] s_req_rdy;
    logic [31:0]      s_des_msg;
    logic [1:0]       s_tag_id;

    typedef struct {
        logic             rst;
        logic [N_REQ-1:0] val;
        logic             drdy;
        logic             exp_dv;
        logic [N_REQ-1:0] exp_rdy;
        logic             exp_busy;
        int               src;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [N_REQ-1:0] val, input logic drdy, input logic trdy);
        logic             e_dv, e_tv;
        logic [N_REQ-1:0] e_rdy;
        logic [31:0]      e_msg;
        int               e_src, e_tid, start;
        @(negedge clk);
        reset       = rst;
        bus.req_val = val;
        bus.des_rdy = drdy;
        bus.tag_rdy = trdy;
        for (int i = 0; i < N_REQ; i++)
            bus.req_msg[i] = BIT_WIDTH'(msg_base[i] + 32'(seq[i]));

        e_dv  = 1'b0;
        e_rdy = '0;
        e_src = -1;
        e_msg = '0;
        if (rst) begin
            if (m_locked) begin
                e_src          = m_owner;
                e_dv           = val[m_owner];
                e_rdy[m_owner] = drdy;
            end else if (m_tags.size() < TAG_DEPTH) begin
                start = FIXED_PRIO ? 0 : m_rr;
                for (int k = 0; k < N_REQ; k++)
                    if (e_src < 0 && val[(start + k) % N_REQ])
                        e_src = (start + k) % N_REQ;
                if (e_src >= 0) begin
                    e_dv         = 1'b1;
                    e_rdy[e_src] = drdy;
                end
            end
        end
        if (e_src >= 0)
            e_msg = msg_base[e_src] + 32'(seq[e_src]);
        e_tv  = rst && (m_tags.size() > 0);
        e_tid = 0;
        if (e_tv)
            e_tid = m_tags[0];

        #1;
        s_des_val = bus.des_val;
        s_req_rdy = bus.req_rdy;
        s_des_msg = bus.des_msg;
        s_busy    = bus.busy;
        s_tag_val = bus.tag_val;
        s_tag_id  = bus.tag_id;
        check("des_val", s_des_val, e_dv);
        check("req_rdy", s_req_rdy, e_rdy);
        check("busy", s_busy, rst && m_locked);
        check("tag_val", s_tag_val, e_tv);
        if (e_dv)
            check("des_msg", s_des_msg, e_msg);
        if (e_tv || !rst)
            check("tag_id", s_tag_id, e_tid);
        if (s_des_val && drdy) begin
            int who = -1;
            for (int i = 0; i < N_REQ; i++)
                if (s_req_rdy[i]) who = i;
            dut_log.push_back(who);
        end

        @(posedge clk);
        if (!rst) begin
            m_locked = 1'b0;
            m_owner  = 0;
            m_beats  = 0;
            m_rr     = 0;
            m_tags.delete();
        end else begin
            if (e_tv && trdy)
                void'(m_tags.pop_front());
            if (e_dv && drdy) begin
                seq[e_src]++;
                if (!m_locked) begin
                    m_locked = 1'b1;
                    m_owner  = e_src;
                    m_beats  = 0;
                end
                m_beats++;
                if (m_beats == N_SAMPLES) begin
                    m_tags.push_back(m_owner);
                    m_rr     = (m_owner + 1) % N_REQ;
                    m_locked = 1'b0;
                    m_beats  = 0;
                end
            end
        end
    endtask

    task automatic run_until(input string name, input int n, input int budget,
                             input logic [N_REQ-1:0] val, input logic drdy, input logic trdy);
        int cyc = 0;
        while (dut_log.size() < n && cyc < budget) begin
            step(1'b1, val, drdy, trdy);
            cyc++;
        end
        check(name, dut_log.size(), n);
    endtask

    function automatic int count_eq(input int from, input int len, input int who);
        int n = 0;
        for (int i = from; i < from + len && i < dut_log.size(); i++)
            if (dut_log[i] == who) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        bus.req_val = '0;
        bus.req_msg = '0;
        bus.des_rdy = 1'b0;
        bus.tag_rdy = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            msg_base[i] = 32'h100 * i;
            seq[i]      = 0;
        end

        //            rst   val      drdy  dv    rdy      busy  src
        tbl[0] = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, -1};
        tbl[1] = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, -1};
        tbl[2] = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1};
        tbl[3] = '{1'b1, 4'b0100, 1'b0, 1'b1, 4'b0000, 1'b0,  2};
        tbl[4] = '{1'b1, 4'b0110, 1'b1, 1'b1, 4'b0010, 1'b0,  1};
        tbl[5] = '{1'b1, 4'b0100, 1'b1, 1'b0, 4'b0010, 1'b1, -1};
        tbl[6] = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1,  1};
        tbl[7] = '{1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, -1};
        tbl[8] = '{1'b1, 4'b0010, 1'b0, 1'b1, 4'b0000, 1'b0,  1};

        for (int r = 0; r < 9; r++) begin
            logic [31:0] exp_msg;
            exp_msg = '0;
            if (tbl[r].src >= 0)
                exp_msg = msg_base[tbl[r].src] + 32'(seq[tbl[r].src]);
            step(tbl[r].rst, tbl[r].val, tbl[r].drdy, 1'b0);
            check("tbl_des_val", s_des_val, tbl[r].exp_dv);
            check("tbl_req_rdy", s_req_rdy, tbl[r].exp_rdy);
            check("tbl_busy", s_busy, tbl[r].exp_busy);
            check("tbl_tag_val", s_tag_val, 1'b0);
            if (tbl[r].src >= 0)
                check("tbl_des_msg", s_des_msg, exp_msg);
        end

        // Single frame from requester 2 with recognisable data.
        step(1'b0, '0, 1'b0, 1'b0);
        msg_base[2] = 32'hA0;
        seq[2]      = 0;
        for (int b = 0; b < N_SAMPLES; b++) begin
            step(1'b1, 4'b0100, 1'b1, 1'b0);
            check("t2_msg", s_des_msg, 32'hA0 + 32'(b));
            check("t2_busy", s_busy, b != 0);
        end
        step(1'b1, 4'b0000, 1'b1, 1'b1);
        check("t2_tag_val", s_tag_val, 1'b1);
        check("t2_tag_id", s_tag_id, 2'd2);
        msg_base[2] = 32'h200;

        // Round-robin across frames with everyone requesting.
        step(1'b0, '0, 1'b0, 1'b0);
        dut_log.delete();
        run_until("t3_xfers", 5 * N_SAMPLES, 100, 4'b1111, 1'b1, 1'b1);
        for (int f = 0; f < 5; f++)
            check("t3_frame_owner", count_eq(f * N_SAMPLES, N_SAMPLES, FIXED_PRIO ? 0 : f % N_REQ), N_SAMPLES);

        // Backpressure and owner gaps inside one frame.
        step(1'b0, '0, 1'b0, 1'b0);
        dut_log.delete();
        begin
            int cyc = 0;
            int nonown = 0;
            while (dut_log.size() < N_SAMPLES && cyc < 100) begin
                step(1'b1, {3'b111, 1'((cyc % 5) != 3)}, 1'((cyc % 2) == 0), 1'b0);
                if (s_req_rdy[3:1] != '0) nonown++;
                cyc++;
            end
            check("t4_xfers", dut_log.size(), N_SAMPLES);
            check("t4_owner", count_eq(0, N_SAMPLES, 0), N_SAMPLES);
            check("t4_nonowner_rdy", nonown, 0);
        end
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        check("t4_busy_after", s_busy, 1'b0);
        check("t4_tag_val", s_tag_val, 1'b1);

        // Tag FIFO full blocks the next frame until a tag is popped.
        step(1'b0, '0, 1'b0, 1'b0);
        dut_log.delete();
        run_until("t5_two_frames", 2 * N_SAMPLES, 60, 4'b0111, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'b0111, 1'b1, 1'b0);
            check("t5_blocked", s_des_val, 1'b0);
        end
        step(1'b1, 4'b0111, 1'b1, 1'b1);
        check("t5_pop_cycle_blocked", s_des_val, 1'b0);
        check("t5_head", s_tag_id, 2'd0);
        step(1'b1, 4'b0111, 1'b1, 1'b0);
        check("t5_resume", s_des_val, 1'b1);
        check("t5_resume_rdy", s_req_rdy, FIXED_PRIO ? 4'b0001 : 4'b0100);
        run_until("t5_third_frame", 3 * N_SAMPLES, 30, 4'b0111, 1'b1, 1'b0);
        check("t5_third_owner", count_eq(2 * N_SAMPLES, N_SAMPLES, FIXED_PRIO ? 0 : 2), N_SAMPLES);

        // Reset in the middle of a frame from requester 1.
        step(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 4'b0010, 1'b1, 1'b1);
        check("t6_busy_mid", s_busy, 1'b1);
        step(1'b0, 4'b1111, 1'b1, 1'b1);
        check("t6_rst_des_val", s_des_val, 1'b0);
        check("t6_rst_rdy", s_req_rdy, 4'b0000);
        check("t6_rst_busy", s_busy, 1'b0);
        dut_log.delete();
        step(1'b1, 4'b1111, 1'b1, 1'b1);
        check("t6_rearb_rdy", s_req_rdy, 4'b0001);
        check("t6_no_tag", s_tag_val, 1'b0);
        run_until("t6_xfers", N_SAMPLES, 30, 4'b1111, 1'b1, 1'b1);
        check("t6_owner", count_eq(0, N_SAMPLES, 0), N_SAMPLES);
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        check("t6_tag_val", s_tag_val, 1'b1);
        check("t6_tag_id", s_tag_id, 2'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic r;
            r = ($urandom_range(0, 63) != 0);
            step(r, N_REQ'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
